// File: rtl/pack.sv
// ---------------------------------------------------------------------------
// pack : shared widths, types and helpers for the my_mem scan read path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pack;

  localparam int ADDRESS_BITS    = 8;
  localparam int DATA_IN_BITS    = 8;
  localparam int DATA_OUT_BITS   = DATA_IN_BITS + 1;
  localparam int SCAN_FIFO_DEPTH = 4;

  typedef logic [DATA_OUT_BITS-1:0] mem_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_fifo.sv
// ---------------------------------------------------------------------------
// scan_fifo : small synchronous FIFO holding {parity_err, data} entries
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scan_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_pop;
  logic             w_push;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CNT_W'(DEPTH));
    w_pop   = pop_i && !empty_o;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    w_push  = push_i && (!full_o || w_pop);
    count_o = count_q;
    data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_scan_reader.sv
// ---------------------------------------------------------------------------
// mem_scan_reader : sweeps an address range of my_mem, checks parity, queues words
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_scan_reader
  import pack::*;
#(
  parameter int ADDR_W     = ADDRESS_BITS,
  parameter int DATA_W     = DATA_IN_BITS,
  parameter int FIFO_DEPTH = SCAN_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W:0]   mem_data_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       err_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  scan_state_t       state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              pending_q;
  logic              done_q;
  logic [15:0]       err_count_q;
  logic [15:0]       err_count_d;

  logic              w_space;
  logic              w_cap_err;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [DATA_W:0]   w_fifo_dout;

  always_comb begin
    // Reserve a slot for the word still in flight from my_mem.
    w_space     = !w_fifo_full &&
                  ((int'(w_fifo_count) + int'(pending_q)) < FIFO_DEPTH);
    mem_read    = (state_q == ISSUE) && w_space;
    mem_address = mem_read ? cur_addr_q : last_addr_q;
    w_cap_err   = mem_data_out[DATA_W] ^ (^mem_data_out[DATA_W-1:0]);
    err_count_d = (pending_q && w_cap_err) ? sat_inc16(err_count_q) : err_count_q;
    w_pop       = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      remaining_q <= '0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      done_q      <= 1'b0;
      pending_q   <= mem_read;
      err_count_q <= err_count_d;
      if (mem_read) begin
        last_addr_q <= cur_addr_q;
        cur_addr_q  <= cur_addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done_q <= 1'b1;
            end else begin
              cur_addr_q  <= base_addr;
              remaining_q <= count;
              err_count_q <= '0;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_read && (remaining_q == (ADDR_W+1)'(1))) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // The only outstanding read is the last one; completion ignores FIFO level.
          if (pending_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  scan_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pending_q),
    .data_i  ({w_cap_err, mem_data_out[DATA_W-1:0]}),
    .pop_i   (w_pop),
    .data_o  (w_fifo_dout),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign out_valid      = !w_fifo_empty;
  assign out_data       = w_fifo_dout[DATA_W-1:0];
  assign out_parity_err = w_fifo_dout[DATA_W];
  assign err_count      = err_count_q;

endmodule

`default_nettype wire
